// File: rtl/ucdp_fifo_thr_pkg.sv
// ucdp_fifo_thr_pkg -- shared types and helpers for the thresholded FIFO.
package ucdp_fifo_thr_pkg;

   // What happens to the fill level in a given cycle.
   typedef enum logic [1:0] {
      fill_hold = 2'd0,
      fill_inc  = 2'd1,
      fill_dec  = 2'd2,
      fill_clr  = 2'd3
   } fill_op_e;

   // Pointer width for a depth that need not be a power of two; at least one bit.
   function automatic int ptr_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/ucdp_fifo_thr_ptr.sv
// ucdp_fifo_thr_ptr -- FIFO pointer counting 0..depth_p-1 and wrapping by explicit compare.
module ucdp_fifo_thr_ptr
   import ucdp_fifo_thr_pkg::*;
#(
   parameter int depth_p     = 5,
   parameter int ptr_width_p = ptr_width(depth_p)
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   input  logic                   i_clr,
   input  logic                   i_inc,
   output logic [ptr_width_p-1:0] o_ptr
);

   localparam logic [ptr_width_p-1:0] c_ptr_max = ptr_width_p'(depth_p - 1);

   logic [ptr_width_p-1:0] r_ptr;

   // Pointer register: flush has priority over increment; wrap at depth_p-1.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         // NOTE: sequential state is always assigned with <= so all flops update from pre-edge values.
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= (r_ptr == c_ptr_max) ? '0 : r_ptr + ptr_width_p'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/ucdp_fifo_thr.sv
// ucdp_fifo_thr -- single-clock FIFO of arbitrary depth with runtime almost-full/empty
// thresholds, synchronous flush, write-through-when-full and peak watermark.
// Define UCDP_FIFO_THR_ERR_EN to build the sticky overflow/underflow flags; otherwise
// ovf_o/udf_o are tied low and err_clr_i is ignored.
module ucdp_fifo_thr
   import ucdp_fifo_thr_pkg::*;
#(
   parameter int width_p         = 8,
   parameter int depth_p         = 5,
   parameter int filling_width_p = $clog2(depth_p + 1)
) (
   input  logic                       main_clk_i,
   input  logic                       main_rst_i,
   input  logic                       dft_mode_test_mode_i,
   input  logic                       dft_mode_scan_mode_i,
   input  logic                       dft_mode_scan_shift_i,
   input  logic                       dft_mode_mbist_mode_i,
   input  logic                       clr_i,
   input  logic                       wr_en_i,
   input  logic [width_p-1:0]         data_i,
   input  logic                       rd_en_i,
   output logic [width_p-1:0]         data_o,
   output logic                       empty_o,
   output logic                       full_o,
   input  logic [filling_width_p-1:0] afull_thr_i,
   input  logic [filling_width_p-1:0] aempty_thr_i,
   output logic                       afull_o,
   output logic                       aempty_o,
   output logic [filling_width_p-1:0] filling_o,
   output logic [filling_width_p-1:0] watermark_o,
   input  logic                       err_clr_i,
   output logic                       ovf_o,
   output logic                       udf_o
);

   localparam int                         c_ptr_width = ptr_width(depth_p);
   localparam logic [filling_width_p-1:0] c_depth     = filling_width_p'(depth_p);

   logic [width_p-1:0]         r_mem [depth_p];
   logic [filling_width_p-1:0] r_filling;
   logic [filling_width_p-1:0] r_watermark;
   logic [filling_width_p-1:0] w_filling_nxt;
   logic [filling_width_p-1:0] w_watermark_nxt;
   logic [c_ptr_width-1:0]     w_rd_ptr;
   logic [c_ptr_width-1:0]     w_wr_ptr;
   logic                       w_empty;
   logic                       w_full;
   logic                       w_rd;
   logic                       w_wr;
   logic                       w_unused;
   fill_op_e                   w_fill_op;

   assign w_empty = (r_filling == '0);
   assign w_full  = (r_filling == c_depth);

   // A pop needs data; a push needs room, or a simultaneous pop freeing the head slot.
   assign w_rd = rd_en_i & ~w_empty;
   assign w_wr = wr_en_i & (~w_full | rd_en_i);

   ucdp_fifo_thr_ptr #(
      .depth_p     (depth_p),
      .ptr_width_p (c_ptr_width)
   ) u_rd_ptr (
      .i_clk (main_clk_i),
      .i_rst (main_rst_i),
      .i_clr (clr_i),
      .i_inc (w_rd),
      .o_ptr (w_rd_ptr)
   );

   ucdp_fifo_thr_ptr #(
      .depth_p     (depth_p),
      .ptr_width_p (c_ptr_width)
   ) u_wr_ptr (
      .i_clk (main_clk_i),
      .i_rst (main_rst_i),
      .i_clr (clr_i),
      .i_inc (w_wr),
      .o_ptr (w_wr_ptr)
   );

   // Storage write; a write coinciding with a flush is dropped.
   // NOTE: the data array has no reset -- contents are only meaningful below filling_o.
   always_ff @(posedge main_clk_i) begin
      if (w_wr && !clr_i) begin
         r_mem[w_wr_ptr] <= data_i;
      end
   end

   // Classify this cycle's effect on the fill level.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch can be inferred.
      w_fill_op = fill_hold;
      if (clr_i) begin
         w_fill_op = fill_clr;
      end else if (w_wr && !w_rd) begin
         w_fill_op = fill_inc;
      end else if (w_rd && !w_wr) begin
         w_fill_op = fill_dec;
      end
   end

   // Next fill level and peak tracking.
   always_comb begin
      w_filling_nxt   = r_filling;
      w_watermark_nxt = r_watermark;
      case (w_fill_op)
         fill_inc:  w_filling_nxt = r_filling + filling_width_p'(1);
         fill_dec:  w_filling_nxt = r_filling - filling_width_p'(1);
         fill_clr:  w_filling_nxt = '0;
         default:   w_filling_nxt = r_filling;
      endcase
      if (w_fill_op == fill_clr) begin
         w_watermark_nxt = '0;
      end else if (w_filling_nxt > r_watermark) begin
         w_watermark_nxt = w_filling_nxt;
      end
   end

   // Fill level and watermark registers.
   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         r_filling   <= '0;
         r_watermark <= '0;
      end else begin
         r_filling   <= w_filling_nxt;
         r_watermark <= w_watermark_nxt;
      end
   end

`ifdef UCDP_FIFO_THR_ERR_EN
   logic r_ovf;
   logic r_udf;

   // Sticky error flags; a new error wins over a simultaneous clear, flush leaves them alone.
   always_ff @(posedge main_clk_i or posedge main_rst_i) begin
      if (main_rst_i) begin
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ovf <= (wr_en_i & w_full & ~rd_en_i) | (r_ovf & ~err_clr_i);
         r_udf <= (rd_en_i & w_empty) | (r_udf & ~err_clr_i);
      end
   end

   assign ovf_o    = r_ovf;
   assign udf_o    = r_udf;
   assign w_unused = ^{dft_mode_test_mode_i, dft_mode_scan_mode_i,
                       dft_mode_scan_shift_i, dft_mode_mbist_mode_i};
`else
   assign ovf_o    = 1'b0;
   assign udf_o    = 1'b0;
   assign w_unused = ^{dft_mode_test_mode_i, dft_mode_scan_mode_i,
                       dft_mode_scan_shift_i, dft_mode_mbist_mode_i, err_clr_i};
`endif

   assign data_o      = r_mem[w_rd_ptr];
   assign empty_o     = w_empty;
   assign full_o      = w_full;
   assign afull_o     = (r_filling >= afull_thr_i);
   assign aempty_o    = (r_filling <= aempty_thr_i);
   assign filling_o   = r_filling;
   assign watermark_o = r_watermark;

endmodule

// File: tb/tb_ucdp_fifo_thr.sv
// tb_ucdp_fifo_thr -- directed self-checking bench for ucdp_fifo_thr (width 8, depth 5).
// Error-flag expectations follow UCDP_FIFO_THR_ERR_EN when it is defined for the build.
module tb_ucdp_fifo_thr;

   localparam int width_p = 8;
   localparam int depth_p = 5;
   localparam int fw_p    = 3;

`ifdef UCDP_FIFO_THR_ERR_EN
   localparam logic c_err = 1'b1;
`else
   localparam logic c_err = 1'b0;
`endif

   logic               clk = 1'b0;
   logic               rst;
   logic               clr;
   logic               wr_en;
   logic [width_p-1:0] din;
   logic               rd_en;
   logic [width_p-1:0] dout;
   logic               empty;
   logic               full;
   logic [fw_p-1:0]    afull_thr;
   logic [fw_p-1:0]    aempty_thr;
   logic               afull;
   logic               aempty;
   logic [fw_p-1:0]    filling;
   logic [fw_p-1:0]    watermark;
   logic               err_clr;
   logic               ovf;
   logic               udf;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   ucdp_fifo_thr #(
      .width_p         (width_p),
      .depth_p         (depth_p),
      .filling_width_p (fw_p)
   ) dut (
      .main_clk_i            (clk),
      .main_rst_i            (rst),
      .dft_mode_test_mode_i  (1'b0),
      .dft_mode_scan_mode_i  (1'b0),
      .dft_mode_scan_shift_i (1'b0),
      .dft_mode_mbist_mode_i (1'b0),
      .clr_i                 (clr),
      .wr_en_i               (wr_en),
      .data_i                (din),
      .rd_en_i               (rd_en),
      .data_o                (dout),
      .empty_o               (empty),
      .full_o                (full),
      .afull_thr_i           (afull_thr),
      .aempty_thr_i          (aempty_thr),
      .afull_o               (afull),
      .aempty_o              (aempty),
      .filling_o             (filling),
      .watermark_o           (watermark),
      .err_clr_i             (err_clr),
      .ovf_o                 (ovf),
      .udf_o                 (udf)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One clock; inputs are changed and outputs sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_status(input string tag, input int fill, input int wm,
                               input logic exp_empty, input logic exp_full);
      check({tag, ".filling"},   32'(filling),   32'(fill));
      check({tag, ".watermark"}, 32'(watermark), 32'(wm));
      check({tag, ".empty"},     32'(empty),     32'(exp_empty));
      check({tag, ".full"},      32'(full),      32'(exp_full));
   endtask

   task automatic push(input logic [7:0] d);
      wr_en = 1'b1;
      din   = d;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic pop();
      rd_en = 1'b1;
      tick();
      rd_en = 1'b0;
   endtask

   initial begin
      logic [7:0] exp_d [5];
      logic       exp_ae [6];
      logic       exp_af [6];
      exp_d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
      exp_ae = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      exp_af = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

      rst        = 1'b1;
      clr        = 1'b0;
      wr_en      = 1'b0;
      rd_en      = 1'b0;
      din        = '0;
      err_clr    = 1'b0;
      afull_thr  = 3'd0;
      aempty_thr = 3'd1;

      // Reset state; afull with threshold 0 is asserted, then tracks a threshold change.
      #3;
      check_status("reset", 0, 0, 1'b1, 1'b0);
      check("reset.aempty", 32'(aempty), 32'd1);
      check("reset.afull_thr0", 32'(afull), 32'd1);
      check("reset.ovf", 32'(ovf), 32'd0);
      check("reset.udf", 32'(udf), 32'd0);
      afull_thr = 3'd4;
      #1;
      check("reset.afull_thr4", 32'(afull), 32'd0);
      tick();
      rst = 1'b0;
      tick();

      // Fill 0..5 with threshold tracking, first-word fall-through after the first write.
      for (int k = 0; k <= depth_p; k++) begin
         check($sformatf("fill%0d.aempty", k), 32'(aempty), 32'(exp_ae[k]));
         check($sformatf("fill%0d.afull", k),  32'(afull),  32'(exp_af[k]));
         check($sformatf("fill%0d.filling", k), 32'(filling), 32'(k));
         if (k > 0) check($sformatf("fill%0d.head", k), 32'(dout), 32'h11);
         if (k < depth_p) push(exp_d[k]);
      end
      check_status("full", 5, 5, 1'b0, 1'b1);

      // Drain in order; both pointers wrap back to slot 0.
      for (int k = 0; k < depth_p; k++) begin
         check($sformatf("drain%0d.data", k), 32'(dout), 32'(exp_d[k]));
         pop();
      end
      check_status("drained", 0, 5, 1'b1, 1'b0);

      // Read on empty with a same-cycle write: write lands, read ignored, underflow flagged.
      wr_en = 1'b1; rd_en = 1'b1; din = 8'h77;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check_status("rdempty", 1, 5, 1'b0, 1'b0);
      check("rdempty.data", 32'(dout), 32'h77);
      check("rdempty.udf", 32'(udf), 32'(c_err));
      tick();
      check("rdempty.udf_sticky", 32'(udf), 32'(c_err));
      pop();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      check("errclr.udf", 32'(udf), 32'd0);
      check("errclr.ovf", 32'(ovf), 32'd0);

      // Refill (pointers sit at 1 now), then write on full without a read is dropped.
      for (int k = 0; k < depth_p; k++) push(exp_d[k]);
      push(8'h99);
      check_status("wrfull", 5, 5, 1'b0, 1'b1);
      check("wrfull.head", 32'(dout), 32'h11);
      check("wrfull.ovf", 32'(ovf), 32'(c_err));
      // New overflow wins over a simultaneous clear.
      err_clr = 1'b1; wr_en = 1'b1; din = 8'h9a;
      tick();
      wr_en = 1'b0;
      check("ovf_set_wins", 32'(ovf), 32'(c_err));
      tick();
      err_clr = 1'b0;
      check("ovf_cleared", 32'(ovf), 32'd0);

      // Write-through when full: head popped, new word appended, level stays at depth.
      wr_en = 1'b1; rd_en = 1'b1; din = 8'h66;
      tick();
      wr_en = 1'b0; rd_en = 1'b0;
      check_status("wrthru", 5, 5, 1'b0, 1'b1);
      check("wrthru.ovf", 32'(ovf), 32'd0);
      for (int k = 1; k <= depth_p; k++) begin
         check($sformatf("wrthru_drain%0d", k), 32'(dout),
               (k < depth_p) ? 32'(exp_d[k]) : 32'h66);
         pop();
      end
      check_status("wrthru_empty", 0, 5, 1'b1, 1'b0);

      // Flush with three entries and a concurrent write.
      push(8'hb1); push(8'hb2); push(8'hb3);
      check("preclr.filling", 32'(filling), 32'd3);
      clr = 1'b1; wr_en = 1'b1; din = 8'hcc;
      tick();
      clr = 1'b0; wr_en = 1'b0;
      check_status("clr", 0, 0, 1'b1, 1'b0);
      check("clr.ovf", 32'(ovf), 32'd0);
      push(8'ha5);
      check_status("postclr", 1, 1, 1'b0, 1'b0);
      check("postclr.data", 32'(dout), 32'ha5);
      // Thresholds are live: lowering afull_thr to 1 asserts afull immediately.
      afull_thr = 3'd1;
      #1;
      check("thr_live.afull", 32'(afull), 32'd1);
      afull_thr = 3'd4;
      pop();

      // Asynchronous reset mid-cycle with three entries stored.
      push(8'hd1); push(8'hd2); push(8'hd3);
      check("prerst.filling", 32'(filling), 32'd3);
      #2;
      rst = 1'b1;
      #1;
      check_status("async_rst", 0, 0, 1'b1, 1'b0);
      check("async_rst.aempty", 32'(aempty), 32'd1);
      check("async_rst.afull", 32'(afull), 32'd0);
      tick();
      rst = 1'b0;
      push(8'he1);
      check_status("post_rst", 1, 1, 1'b0, 1'b0);
      check("post_rst.data", 32'(dout), 32'he1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
